// File: rtl/fsm_ctrl_pkg.sv
// Shared definitions for the multi-channel job controller: state encoding
// and the index-width helper used by the controller and its arbiter.
package fsm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  // Width of a binary index into n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the entry after
// `last`. The upper copy of the request vector holds every request. The
// lower copy keeps only the entries above `last`. The lowest set bit of the
// doubled vector is therefore the next requester in rotation.
module rr_arbiter
  import fsm_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   last,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  any
);

  localparam int IW = idx_w(N);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           hit;

  // Mask off entries at or below the last winner, then find the first set bit.
  always_comb begin
    for (int i = 0; i < N; i++) mask[i] = (i > int'(last));
    dbl = {req, req & mask};
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    any = |req;
    for (int i = 0; i < 2*N; i++) begin
      if (!hit && dbl[i]) begin
        hit        = 1'b1;
        gnt[i % N] = 1'b1;
        idx        = IW'(i % N);
      end
    end
  end

endmodule

// File: rtl/fsm_multi_ctrl.sv
// Multi-channel job controller. It latches start requests per channel and
// serves them one at a time in round-robin order. Each job is supervised by
// a watchdog. All outputs are registered (Moore).
module fsm_multi_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int TIMEOUT = 16,
  localparam int CW      = idx_w(N_CH),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] start,
  input  logic            done,
  input  logic            abort,
  output logic            busy,
  output logic            ready,
  output logic [N_CH-1:0] grant,
  output logic [CW-1:0]   ch_id,
  output logic [N_CH-1:0] done_ch,
  output logic            timeout,
  output logic [N_CH-1:0] pending
);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [CW-1:0]     ch_id_q, ch_id_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [N_CH-1:0]   done_ch_q, done_ch_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   arb_gnt;
  logic [CW-1:0]     arb_idx;
  logic              arb_any;

  assign req = pending_q | start;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req  (req),
    .last (ch_id_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Next-state logic: FSM, request latching, watchdog and output pulses.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ch_id_d   = ch_id_q;
    pending_d = req;
    cnt_d     = cnt_q;
    done_ch_d = '0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          pending_d = '0;
        end else if (arb_any) begin
          state_d   = ST_WORK;
          grant_d   = arb_gnt;
          ch_id_d   = arb_idx;
          cnt_d     = '0;
          pending_d = req & ~arb_gnt;
        end
      end
      ST_WORK: begin
        if (abort) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          pending_d = '0;
        end else if (done) begin
          state_d   = ST_DONE;
          done_ch_d = grant_q;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = ST_TOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE, ST_TOUT: begin
        // The pulse is already on the outputs; always fall back to IDLE.
        state_d = ST_IDLE;
        grant_d = '0;
        if (abort) pending_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ch_id_q   <= CW'(N_CH - 1);
      pending_q <= '0;
      done_ch_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ch_id_q   <= ch_id_d;
      pending_q <= pending_d;
      done_ch_q <= done_ch_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign busy    = busy_q;
  assign ready   = ready_q;
  assign grant   = grant_q;
  assign ch_id   = ch_id_q;
  assign done_ch = done_ch_q;
  assign timeout = timeout_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_fsm_multi_ctrl.sv
// Self-checking bench for fsm_multi_ctrl (N_CH=4, TIMEOUT=16). Inputs change
// and outputs are sampled on the falling edge. Expected completions are
// queued when a job is launched and are popped when the pulse appears.
module tb_fsm_multi_ctrl;

  localparam int N_CH    = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = 2;

  typedef struct {
    logic [N_CH-1:0] grant;
    logic            tout;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] start;
  logic            done;
  logic            abort;
  logic            busy, ready, timeout;
  logic [N_CH-1:0] grant, done_ch, pending;
  logic [CW-1:0]   ch_id;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  fsm_multi_ctrl #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .done    (done),
    .abort   (abort),
    .busy    (busy),
    .ready   (ready),
    .grant   (grant),
    .ch_id   (ch_id),
    .done_ch (done_ch),
    .timeout (timeout),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = '0; done = 1'b0; abort = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (ch_id !== 2'd3) begin errors++; $display("FAIL reset_ch_id: got %0d want 3", ch_id); end
    checks++; if (done_ch !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done_ch=%b timeout=%b want 0000/0", done_ch, timeout); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    start = 4'b0001;
    sb.push_back('{grant: 4'b0001, tout: 1'b0});
    tick();
    start = '0;
    checks++; if (grant !== 4'b0001 || busy !== 1'b1 || ch_id !== 2'd0) begin errors++; $display("FAIL basic_launch: got grant=%b busy=%b ch=%0d want 0001/1/0", grant, busy, ch_id); end
    tick();
    tick();
    checks++; if (busy !== 1'b1 || done_ch !== 4'b0000) begin errors++; $display("FAIL basic_work3: got busy=%b done_ch=%b want 1/0000", busy, done_ch); end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL basic_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (done_ch !== e.grant || timeout !== e.tout) begin errors++; $display("FAIL basic_done: got done_ch=%b timeout=%b want %b/%b", done_ch, timeout, e.grant, e.tout); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    tick();
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000 || done_ch !== 4'b0000) begin errors++; $display("FAIL basic_idle: got ready=%b busy=%b grant=%b done_ch=%b want 1/0/0000/0000", ready, busy, grant, done_ch); end
  endtask

  // Three jobs latched in one cycle; each idle gap between them is one cycle.
  task automatic test_back_to_back();
    logic [N_CH-1:0] exp_g[3];
    logic [N_CH-1:0] exp_p[3];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    exp_p[0] = 4'b1010; exp_p[1] = 4'b1000; exp_p[2] = 4'b0000;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    start = 4'b1011;
    for (int k = 0; k < 3; k++) sb.push_back('{grant: exp_g[k], tout: 1'b0});
    for (int k = 0; k < 3; k++) begin
      tick();
      start = '0;
      checks++; if (grant !== exp_g[k] || pending !== exp_p[k]) begin errors++; $display("FAIL rr_grant%0d: got grant=%b pending=%b want %b/%b", k, grant, pending, exp_g[k], exp_p[k]); end
      done = 1'b1;
      tick();
      done = 1'b0;
      if (sb.size() == 0) begin checks++; errors++; $display("FAIL rr_sb%0d: got empty queue want entry", k); end
      else begin
        e = sb.pop_front();
        checks++; if (done_ch !== e.grant || timeout !== e.tout) begin errors++; $display("FAIL rr_done%0d: got done_ch=%b timeout=%b want %b/%b", k, done_ch, timeout, e.grant, e.tout); end
      end
      tick();
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got ready=%b busy=%b want 1/0", k, ready, busy); end
    end
  endtask

  task automatic test_timeout();
    start = 4'b0100;
    sb.push_back('{grant: 4'b0100, tout: 1'b1});
    tick();
    start = '0;
    checks++; if (grant !== 4'b0100 || ch_id !== 2'd2) begin errors++; $display("FAIL tout_launch: got grant=%b ch=%0d want 0100/2", grant, ch_id); end
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      checks++; if (timeout !== 1'b0 || busy !== 1'b1 || grant !== 4'b0100) begin errors++; $display("FAIL tout_work%0d: got timeout=%b busy=%b grant=%b want 0/1/0100", i, timeout, busy, grant); end
    end
    tick();
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL tout_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (timeout !== e.tout || done_ch !== 4'b0000 || grant !== e.grant) begin errors++; $display("FAIL tout_pulse: got timeout=%b done_ch=%b grant=%b want %b/0000/%b", timeout, done_ch, grant, e.tout, e.grant); end
    end
    tick();
    checks++; if (timeout !== 1'b0 || ready !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL tout_idle: got timeout=%b ready=%b pending=%b want 0/1/0000", timeout, ready, pending); end
    tick();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL tout_no_requeue: got busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  // done raised in the final WORK cycle must win over the watchdog.
  task automatic test_boundary();
    start = 4'b0010;
    sb.push_back('{grant: 4'b0010, tout: 1'b0});
    tick();
    start = '0;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bnd_launch: got %b want 0010", grant); end
    for (int i = 2; i <= TIMEOUT; i++) tick();
    checks++; if (busy !== 1'b1 || timeout !== 1'b0 || done_ch !== 4'b0000) begin errors++; $display("FAIL bnd_last_work: got busy=%b timeout=%b done_ch=%b want 1/0/0000", busy, timeout, done_ch); end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL bnd_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (done_ch !== e.grant || timeout !== e.tout) begin errors++; $display("FAIL bnd_pulse: got done_ch=%b timeout=%b want %b/%b", done_ch, timeout, e.grant, e.tout); end
    end
    tick();
    checks++; if (ready !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL bnd_idle: got ready=%b timeout=%b want 1/0", ready, timeout); end
  endtask

  task automatic test_abort();
    // Abort in IDLE swallows a same-cycle start.
    start = 4'b0001; abort = 1'b1;
    tick();
    start = '0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL abort_idle: got busy=%b pending=%b want 0/0000", busy, pending); end
    // done outside WORK is ignored.
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (busy !== 1'b0 || done_ch !== 4'b0000) begin errors++; $display("FAIL done_in_idle: got busy=%b done_ch=%b want 0/0000", busy, done_ch); end
    // Pointer sits at ch1, so ch2 wins and ch0/ch1 stay pending.
    start = 4'b0111;
    tick();
    start = '0;
    checks++; if (grant !== 4'b0100 || pending !== 4'b0011) begin errors++; $display("FAIL abort_launch: got grant=%b pending=%b want 0100/0011", grant, pending); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || pending !== 4'b0000 || grant !== 4'b0000) begin errors++; $display("FAIL abort_work: got ready=%b busy=%b pending=%b grant=%b want 1/0/0000/0000", ready, busy, pending, grant); end
    checks++; if (done_ch !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL abort_pulses: got done_ch=%b timeout=%b want 0000/0", done_ch, timeout); end
    tick();
    checks++; if (busy !== 1'b0 || done_ch !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL abort_after: got busy=%b done_ch=%b timeout=%b want 0/0000/0", busy, done_ch, timeout); end
  endtask

  task automatic test_reset_mid_job();
    // Pointer at ch2: ch1 is served first and ch2 stays pending.
    start = 4'b0110;
    tick();
    start = '0;
    checks++; if (grant !== 4'b0010 || pending !== 4'b0100) begin errors++; $display("FAIL rst_mid_launch: got grant=%b pending=%b want 0010/0100", grant, pending); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || grant !== 4'b0000 || ch_id !== 2'd3) begin errors++; $display("FAIL rst_mid_state: got busy=%b ready=%b grant=%b ch=%0d want 0/1/0000/3", busy, ready, grant, ch_id); end
    checks++; if (pending !== 4'b0000 || done_ch !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got pending=%b done_ch=%b timeout=%b want 0000/0000/0", pending, done_ch, timeout); end
    start = 4'b0010;
    sb.push_back('{grant: 4'b0010, tout: 1'b0});
    tick();
    start = '0;
    checks++; if (grant !== 4'b0010 || ch_id !== 2'd1) begin errors++; $display("FAIL rst_mid_serve: got grant=%b ch=%0d want 0010/1", grant, ch_id); end
    done = 1'b1;
    tick();
    done = 1'b0;
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL rst_mid_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      checks++; if (done_ch !== e.grant || timeout !== e.tout) begin errors++; $display("FAIL rst_mid_done: got done_ch=%b timeout=%b want %b/%b", done_ch, timeout, e.grant, e.tout); end
    end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got ready=%b want 1", ready); end
  endtask

  initial begin
    reset = 1'b1; start = '0; done = 1'b0; abort = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_boundary();
    test_abort();
    test_reset_mid_job();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d entries left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
